div_ceil_seq: RTL

// - Multi-cycle unsigned ceiling divider: q = ceil(n/d), plus remainder of floor division.
// - Hardware counterpart of math_pkg::div_ceil, for run-time operands (e.g. beat/line counts).
// - Radix-2 restoring datapath, sequenced by an internal FSM, valid/ready on both sides.
// - One operation in flight. Sits between a config/descriptor stage and its consumer.
//

---
 rtl/div_ceil_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/div_ceil_seq.sv
// Multi-cycle unsigned ceiling divider (radix-2 restoring) with valid/ready on both sides.
// Optional build macro DIV_CEIL_SEQ_EARLY_OUT_EN: operations with n < d finish in one cycle.
module div_ceil_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_n,
  input  logic [W-1:0] in_d,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_r,
  output logic         out_dz,
  output logic         busy
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   d_q, d_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   qres_q, qres_d;
  logic [W-1:0]   rres_q, rres_d;
  logic           dz_q, dz_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [W:0]     rem_sh;
  logic [W:0]     rem_sub;
  logic           first_cyc;
  logic           early_out;

  always_comb begin
    rem_sh    = {rem_q, quo_q[W-1]};
    rem_sub   = rem_sh - {1'b0, d_q};
    // quo_q still holds the untouched dividend on the first BUSY cycle
    first_cyc = (cnt_q == CW'(W));
`ifdef DIV_CEIL_SEQ_EARLY_OUT_EN
    early_out = (quo_q < d_q);
`else
    early_out = 1'b0;
`endif

    state_d = state_q;
    d_d     = d_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qres_d  = qres_q;
    rres_d  = rres_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_vld) begin
          d_d     = in_d;
          quo_d   = in_n;
          rem_d   = '0;
          cnt_d   = CW'(W);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (first_cyc && (d_q == '0)) begin
          qres_d  = '1;
          rres_d  = quo_q;
          dz_d    = 1'b1;
          state_d = DONE;
        end else if (first_cyc && early_out) begin
          qres_d  = {{(W-1){1'b0}}, (quo_q != '0)};
          rres_d  = quo_q;
          dz_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == '0) begin
          // No overflow: a nonzero remainder implies d >= 2, so quo <= (2^W-1)/2
          qres_d  = quo_q + {{(W-1){1'b0}}, (rem_q != '0)};
          rres_d  = rem_q;
          dz_d    = 1'b0;
          state_d = DONE;
        end else begin
          if (rem_sh >= {1'b0, d_q}) begin
            rem_d = rem_sub[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (out_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      qres_q  <= '0;
      rres_q  <= '0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qres_q  <= qres_d;
      rres_q  <= rres_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_rdy  = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign out_vld = (state_q == DONE);
  assign out_q   = qres_q;
  assign out_r   = rres_q;
  assign out_dz  = dz_q;

endmodule
